// File: rtl/counter_top_pkg.sv
// Shared constants for the 4-digit up/down counter with multiplexed 7-segment display.
// Holds count range, default divider ratios, digit-select reset pattern and segment codes.
package counter_top_pkg;

    localparam int unsigned MAX_COUNT    = 9999;
    localparam int unsigned COUNT_W      = 14;
    localparam int unsigned TICK_DIV_DEF = 10_000_000;
    localparam int unsigned SCAN_DIV_DEF = 100_000;

    // Active-low segment codes {dp,g,f,e,d,c,b,a}; dp stays off (1) in every code
    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    localparam logic [3:0] COM_RESET = 4'b1110;

    // BCD digit to active-low segment pattern; non-decimal values blank the digit
    function automatic logic [7:0] seg_decode(input logic [3:0] digit);
        logic [7:0] seg;
        case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/fnd_controller.sv
// Scans the four digits of a 0..9999 value onto a multiplexed 7-segment display.
// Ports: clk, rst (async active-low), count (value to show, 14b),
//        fnd_com (active-low digit select, bit0 = ones), fnd_data (active-low segments).
// count is the counter's next-state value, so the registered outputs track the
// count on the same edge that the count register changes.
module fnd_controller
    import counter_top_pkg::*;
#(
    parameter int unsigned SCAN_DIV = SCAN_DIV_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [COUNT_W-1:0] count,
    output logic [3:0]         fnd_com,
    output logic [7:0]         fnd_data
);

    localparam int unsigned SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [SCAN_W-1:0] scan_cnt;
    logic              w_clk_div;
    logic [1:0]        digit_idx;
    logic [1:0]        digit_idx_d;
    logic [3:0]        digit_val;

    // Scan divider: one-cycle pulse every SCAN_DIV clocks
    assign w_clk_div = (scan_cnt == SCAN_W'(SCAN_DIV - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scan_cnt <= '0;
        end else if (w_clk_div) begin
            scan_cnt <= '0;
        end else begin
            scan_cnt <= scan_cnt + SCAN_W'(1);
        end
    end

    assign digit_idx_d = w_clk_div ? digit_idx + 2'd1 : digit_idx;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            digit_idx <= 2'd0;
        end else begin
            digit_idx <= digit_idx_d;
        end
    end

    // BCD split and digit mux, keyed on the index being loaded this edge
    always_comb begin
        digit_val = 4'd0;
        case (digit_idx_d)
            2'd0: digit_val = 4'(count % COUNT_W'(10));
            2'd1: digit_val = 4'((count / COUNT_W'(10)) % COUNT_W'(10));
            2'd2: digit_val = 4'((count / COUNT_W'(100)) % COUNT_W'(10));
            2'd3: digit_val = 4'(count / COUNT_W'(1000));
            default: digit_val = 4'd0;
        endcase
    end

    // Select and segment registers load together so digits never blank between steps
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fnd_com  <= COM_RESET;
            fnd_data <= SEG_0;
        end else begin
            fnd_com  <= ~(4'b0001 << digit_idx_d);
            fnd_data <= seg_decode(digit_val);
        end
    end

endmodule

// File: rtl/counter_top.sv
// 4-digit decimal up/down counter (0..9999) stepped by a free-running tick divider,
// shown on a multiplexed 7-segment display.
// Ports: clk, rst (async active-low), mode (0 up / 1 down), enable, clear (sync, level),
//        fnd_com (active-low digit select), fnd_data (active-low segments {dp,g..a}).
module counter_top
    import counter_top_pkg::*;
#(
    parameter int unsigned TICK_DIV = TICK_DIV_DEF,
    parameter int unsigned SCAN_DIV = SCAN_DIV_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       mode,
    input  logic       enable,
    input  logic       clear,
    output logic [3:0] fnd_com,
    output logic [7:0] fnd_data
);

    localparam int unsigned TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [TICK_W-1:0]  tick_cnt;
    logic               tick;
    logic [COUNT_W-1:0] count;
    logic [COUNT_W-1:0] count_d;

    // Tick divider free-runs regardless of enable
    assign tick = (tick_cnt == TICK_W'(TICK_DIV - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + TICK_W'(1);
        end
    end

    // Next count: clear beats tick; wrap at both ends of 0..9999
    always_comb begin
        count_d = count;
        if (clear) begin
            count_d = '0;
        end else if (tick && enable) begin
            if (mode) begin
                count_d = (count == '0) ? COUNT_W'(MAX_COUNT) : count - COUNT_W'(1);
            end else begin
                count_d = (count == COUNT_W'(MAX_COUNT)) ? '0 : count + COUNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else begin
            count <= count_d;
        end
    end

    fnd_controller #(
        .SCAN_DIV (SCAN_DIV)
    ) U_FND_CONTROLLER (
        .clk      (clk),
        .rst      (rst),
        .count    (count_d),
        .fnd_com  (fnd_com),
        .fnd_data (fnd_data)
    );

endmodule

// File: tb/tb_counter_top.sv
// Self-checking bench for counter_top with reduced divider ratios.
module tb_counter_top;

    localparam int TICK = 20;
    localparam int SCAN = 3;
    localparam logic [7:0] SEG_TBL [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                           8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

    logic       clk;
    logic       rst;
    logic       mode;
    logic       enable;
    logic       clear;
    logic [3:0] fnd_com;
    logic [7:0] fnd_data;

    int err_cnt = 0;
    int chk_cnt = 0;
    bit mon_on  = 0;

    // Reference model state: edges since reset release and the expected count
    int edge_n;
    int m_count;

    counter_top #(
        .TICK_DIV (TICK),
        .SCAN_DIV (SCAN)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .mode     (mode),
        .enable   (enable),
        .clear    (clear),
        .fnd_com  (fnd_com),
        .fnd_data (fnd_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int dig(input int c, input int i);
        int p = 1;
        for (int k = 0; k < i; k++) p = p * 10;
        return (c / p) % 10;
    endfunction

    // Model: tick on every TICK-th edge after reset, scan index advances every SCAN edges
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            edge_n  <= 0;
            m_count <= 0;
        end else begin
            edge_n <= edge_n + 1;
            if (clear)
                m_count <= 0;
            else if (enable && ((edge_n + 1) % TICK == 0))
                m_count <= mode ? (m_count + 9999) % 10000 : (m_count + 1) % 10000;
        end
    end

    // Cycle-by-cycle comparison against the model
    always @(negedge clk) begin
        if (mon_on && rst) begin
            int idx;
            logic [3:0] exp_com;
            idx     = (edge_n / SCAN) % 4;
            exp_com = ~(4'b0001 << idx);
            check("mon_count", 32'(dut.count), 32'(m_count));
            check("mon_com",   32'(fnd_com),   32'(exp_com));
            check("mon_data",  32'(fnd_data),  32'(SEG_TBL[dig(m_count, idx)]));
            check("mon_scan_pulse", 32'(dut.U_FND_CONTROLLER.w_clk_div),
                  32'((edge_n % SCAN) == SCAN - 1));
        end
    end

    initial begin
        int n;
        bit found;
        logic [3:0] seen;
        logic [3:0] prev_com;
        int rot;

        rst = 1'b0; mode = 1'b0; enable = 1'b0; clear = 1'b0;

        // Reset state
        #10 rst = 1'b1;
        #2;
        check("rst_com",   32'(fnd_com),   32'h0000_000E);
        check("rst_data",  32'(fnd_data),  32'h0000_00C0);
        check("rst_count", 32'(dut.count), 32'd0);
        mon_on = 1'b1;

        // Up count for five tick periods
        @(negedge clk);
        enable = 1'b1; mode = 1'b0;
        repeat (5 * TICK) @(negedge clk);
        check("up_count5", 32'(dut.count), 32'd5);
        found = 1'b0;
        for (int i = 0; i < 4 * SCAN; i++) begin
            if (fnd_com == 4'b1110) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("up_ones_sel_seen", 32'(found), 32'd1);
        check("up_ones_data", 32'(fnd_data), 32'h92);

        // Clear held for 10 cycles mid-count
        repeat (7) @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        check("clear_next_edge", 32'(dut.count), 32'd0);
        repeat (9) @(negedge clk);
        check("clear_held", 32'(dut.count), 32'd0);
        clear = 1'b0;
        n = 0;
        while (dut.count == 14'd0 && n < TICK + 2) begin
            @(negedge clk);
            n++;
        end
        check("clear_resume", 32'(dut.count), 32'd1);

        // Down wrap from zero
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0; mode = 1'b1;
        n = 0;
        while (dut.count == 14'd0 && n < TICK + 2) begin
            @(negedge clk);
            n++;
        end
        check("down_wrap", 32'(dut.count), 32'd9999);
        enable = 1'b0;
        seen = 4'b0000;
        for (int i = 0; i < 4 * SCAN; i++) begin
            @(negedge clk);
            check("wrap_digit_9", 32'(fnd_data), 32'h90);
            seen = seen | ~fnd_com;
        end
        check("wrap_all_digits", 32'(seen), 32'hF);

        // Hold with a mode change while disabled; scan keeps rotating
        mode = 1'b0;
        prev_com = fnd_com;
        rot = 0;
        repeat (10 * TICK) begin
            @(negedge clk);
            if (fnd_com != prev_com) begin
                check("hold_rotate", 32'(fnd_com), 32'({prev_com[2:0], prev_com[3]}));
                prev_com = fnd_com;
                rot++;
            end
        end
        check("hold_count", 32'(dut.count), 32'd9999);
        check("hold_scan_steps", 32'(rot >= (10 * TICK) / SCAN - 1), 32'd1);

        // Up wrap using the mode set during hold
        enable = 1'b1;
        n = 0;
        while (dut.count == 14'd9999 && n < TICK + 2) begin
            @(negedge clk);
            n++;
        end
        check("up_wrap", 32'(dut.count), 32'd0);

        // Async reset between clock edges
        repeat (7) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("async_rst_com",   32'(fnd_com),   32'h0000_000E);
        check("async_rst_data",  32'(fnd_data),  32'h0000_00C0);
        check("async_rst_count", 32'(dut.count), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        n = 0;
        while (dut.count == 14'd0 && n < TICK + 5) begin
            @(negedge clk);
            n++;
        end
        check("first_tick_latency", 32'(n), 32'(TICK));

        // Randomized controls against the model
        repeat (800) begin
            @(negedge clk);
            enable = ($urandom_range(0, 3) != 0);
            mode   = 1'($urandom_range(0, 1));
            clear  = ($urandom_range(0, 63) == 0);
        end

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
